ntt_banked_ram: RTL and testbench
=================================

// Module: ntt_banked_ram
// PURPOSE
//  Parametrised multi-bank simple-dual-port block RAM for the NTT datapath: NBANK
//  independent banks, each 2^HLEN x DLEN, one write and one read port per bank.
//  Adds per-bank read valid, an optional output pipeline register, a hardware
//  zero-fill (clear) sequencer and optional same-address write-to-read forwarding.
//  Sits between the butterfly units and the address generator. Holds coefficients
//  and twiddle factors.
// PARAMETERS
//  DLEN   23  data width per word
//  HLEN   8   address width; bank depth = 2^HLEN
//  NBANK  4   number of banks (>=1)
//  OREG   0   1 = extra output register stage; read latency = 1+OREG
// PORTS
//  clk     in   1            single clock, rising edge
//  rst_n   in   1            asynchronous, active-low reset
//  clr_req in   1            pulse: start zero-fill of all banks
//  clr_bsy out  1            high while zero-fill runs
//  wen     in   NBANK        per-bank write enable
//  waddr   in   NBANK*HLEN   bank b address = waddr[b*HLEN +: HLEN]
//  din     in   NBANK*DLEN   bank b data = din[b*DLEN +: DLEN]
//  ren     in   NBANK        per-bank read enable
//  raddr   in   NBANK*HLEN   packed like waddr
//  dout    out  NBANK*DLEN   packed like din
//  dvalid  out  NBANK        bank b dout valid
// BEHAVIOUR
//  - Reset: dout=0, dvalid=0, clr_bsy=0, FSM=IDLE, clear counter=0. The array is
//    not reset.
//  - Write: wen[b]=1 at edge -> mem_b[waddr_b]<=din_b. No write at wen[b]=0.
//  - Read: ren[b]=1 at edge t -> dout_b/dvalid[b]=1 at edge t+1+OREG. dvalid
//    follows ren through the same pipe. dout holds its last value when dvalid=0.
//  - Same bank, same address, same cycle read+write: read returns the OLD data.
//    Without forwarding this is read-first behaviour.
//  - FSM: IDLE --clr_req--> CLEAR. CLEAR writes 0 to address cnt in all banks per
//    cycle, cnt 0..2^HLEN-1. At cnt=2^HLEN-1 it returns to IDLE, cnt wraps to 0.
//    Clear takes exactly 2^HLEN cycles. clr_bsy=1 exactly while in CLEAR.
//  - During CLEAR: user wen ignored. ren ignored (dvalid stays 0). clr_req ignored.
//    Reads issued before CLEAR still drain through the OREG pipe.
//  - clr_req in the same cycle as wen: clear wins. The user write is dropped.
//  - rst_n asserted mid-clear: FSM goes to IDLE immediately. The array is left
//    partially cleared, with no completion indication.
// CONFIGURATION
//  - Macro NTT_BANKED_RAM_FWD_EN defined: same-bank read+write to the same address
//    in one cycle returns din (write-first). Compare and mux sit before the first
//    output register, latency is unchanged.
//  - Macro not defined: read-first as above, no comparator logic.
// STRUCTURE
//  - Package ntt_mem_pkg: default DLEN/HLEN/NBANK constants, clear FSM state enum
//    (ST_IDLE, ST_CLEAR), bank slice helper widths.
//  - Sub-module ntt_ram_bank: one bank = array, write port, read register, optional
//    OREG stage, forwarding mux. Instantiated NBANK times in a generate loop.
//  - Top level: clear FSM/counter, wen/din muxing (user vs clear), ren gating.
// TESTING
//  1 Reset, then ren=all ones at addr 0 -> dvalid rises 1+OREG cycles later.
//    dout=X-free only after a write. Checks dvalid/dout reset to 0.
//  2 Write bank1 addr 5=0x1234, read next cycle -> dout1=0x1234, dvalid=0010 at
//    latency 1+OREG. Other banks are unchanged.
//  3 Write+read bank0 addr 7 same cycle (old=0xA, din=0xB) -> dout0=0xA. With
//    NTT_BANKED_RAM_FWD_EN defined: 0xB.
//  4 Fill all banks, pulse clr_req -> clr_bsy high exactly 2^HLEN cycles. wen/ren
//    are ignored while busy. All addresses then read 0.
//  5 clr_req together with wen bank2 addr 3=0x77 -> addr 3 reads 0. A second
//    clr_req while busy does not extend clr_bsy.
//  6 Drop rst_n at cnt=100 -> clr_bsy=0 asynchronously. Addr 0..99 read 0, and
//    addr>=101 keeps the old data.

Source files
------------

// File: rtl/ntt_mem_pkg.sv
// Shared constants and types for the banked NTT coefficient/twiddle RAM.
// Optional feature macro: NTT_BANKED_RAM_FWD_EN (write-first forwarding).
package ntt_mem_pkg;

   localparam int DEF_DLEN  = 23;
   localparam int DEF_HLEN  = 8;
   localparam int DEF_NBANK = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_st_e;

   // Width of a packed per-bank bus: n banks of w bits each.
   function automatic int bus_w(int n, int w);
      return n * w;
   endfunction

endpackage

// File: rtl/ntt_banked_ram_if.sv
// Bus bundle for the banked RAM: clear control plus per-bank
// write and read ports, packed bank-major.
interface ntt_banked_ram_if #(
   parameter int DLEN  = 23,
   parameter int HLEN  = 8,
   parameter int NBANK = 4
);

   logic                  clr_req;
   logic                  clr_bsy;
   logic [NBANK-1:0]      wen;
   logic [NBANK*HLEN-1:0] waddr;
   logic [NBANK*DLEN-1:0] din;
   logic [NBANK-1:0]      ren;
   logic [NBANK*HLEN-1:0] raddr;
   logic [NBANK*DLEN-1:0] dout;
   logic [NBANK-1:0]      dvalid;

   modport master (
      output clr_req, wen, waddr, din, ren, raddr,
      input  clr_bsy, dout, dvalid
   );

   modport slave (
      input  clr_req, wen, waddr, din, ren, raddr,
      output clr_bsy, dout, dvalid
   );

endinterface

// File: rtl/ntt_ram_bank.sv
// One simple-dual-port RAM bank with registered read, optional
// output stage and optional write-first forwarding (NTT_BANKED_RAM_FWD_EN).
module ntt_ram_bank
   import ntt_mem_pkg::*;
#(
   parameter int DLEN = DEF_DLEN,
   parameter int HLEN = DEF_HLEN,
   parameter int OREG = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_wen,
   input  logic [HLEN-1:0] i_waddr,
   input  logic [DLEN-1:0] i_din,
   input  logic            i_ren,
   input  logic [HLEN-1:0] i_raddr,
   output logic [DLEN-1:0] o_dout,
   output logic            o_dvalid
);

   localparam int DEPTH = 1 << HLEN;

   logic [DLEN-1:0] r_mem [DEPTH];
   logic [DLEN-1:0] r_rd;
   logic            r_vld;
   logic [DLEN-1:0] w_rdata;

`ifdef NTT_BANKED_RAM_FWD_EN
   assign w_rdata = (i_wen && (i_waddr == i_raddr)) ? i_din
                                                    : r_mem[i_raddr];
`else
   assign w_rdata = r_mem[i_raddr];
`endif

   // Array write port; the array itself is never reset.
   always_ff @(posedge clk) begin
      if (i_wen) r_mem[i_waddr] <= i_din;
   end

   // First read stage: data updates only on a read, valid tracks ren.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd  <= '0;
         r_vld <= 1'b0;
      end else begin
         r_vld <= i_ren;
         if (i_ren) r_rd <= w_rdata;
      end
   end

   generate
      if (OREG != 0) begin : g_oreg
         logic [DLEN-1:0] r_q;
         logic            r_qv;

         // Extra output stage, holding data between valid reads.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_q  <= '0;
               r_qv <= 1'b0;
            end else begin
               r_qv <= r_vld;
               if (r_vld) r_q <= r_rd;
            end
         end

         assign o_dout   = r_q;
         assign o_dvalid = r_qv;
      end else begin : g_noreg
         assign o_dout   = r_rd;
         assign o_dvalid = r_vld;
      end
   endgenerate

endmodule

// File: rtl/ntt_banked_ram.sv
// NBANK-bank NTT RAM: clear sequencer, user/clear port muxing
// and read gating. Optional feature macro: NTT_BANKED_RAM_FWD_EN.
module ntt_banked_ram
   import ntt_mem_pkg::*;
#(
   parameter int DLEN  = DEF_DLEN,
   parameter int HLEN  = DEF_HLEN,
   parameter int NBANK = DEF_NBANK,
   parameter int OREG  = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   ntt_banked_ram_if.slave bus
);

   localparam int AW = bus_w(NBANK, HLEN);
   localparam int DW = bus_w(NBANK, DLEN);
   localparam logic [HLEN-1:0] CNT_MAX = '1;

   clr_st_e         r_st;
   logic [HLEN-1:0] r_cnt;
   logic            r_bsy;

   logic             w_clr;
   logic [NBANK-1:0] w_wen;
   logic [AW-1:0]    w_waddr;
   logic [DW-1:0]    w_din;
   logic [NBANK-1:0] w_ren;

   // Clear sequencer: sweeps every address once, busy flag registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_st  <= ST_IDLE;
         r_cnt <= '0;
         r_bsy <= 1'b0;
      end else begin
         unique case (r_st)
            ST_IDLE: begin
               if (bus.clr_req) begin
                  r_st  <= ST_CLEAR;
                  r_bsy <= 1'b1;
                  r_cnt <= '0;
               end
            end
            ST_CLEAR: begin
               if (r_cnt == CNT_MAX) begin
                  r_st  <= ST_IDLE;
                  r_bsy <= 1'b0;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign w_clr   = (r_st == ST_CLEAR);
   // A clear request drops any user write issued in the same cycle.
   assign w_wen   = w_clr ? '1
                          : (bus.wen & {NBANK{~bus.clr_req}});
   assign w_waddr = w_clr ? {NBANK{r_cnt}} : bus.waddr;
   assign w_din   = w_clr ? '0 : bus.din;
   assign w_ren   = bus.ren & {NBANK{~w_clr}};

   assign bus.clr_bsy = r_bsy;

   generate
      for (genvar b = 0; b < NBANK; b++) begin : g_bank
         ntt_ram_bank #(
            .DLEN (DLEN),
            .HLEN (HLEN),
            .OREG (OREG)
         ) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_wen    (w_wen[b]),
            .i_waddr  (w_waddr[b*HLEN +: HLEN]),
            .i_din    (w_din[b*DLEN +: DLEN]),
            .i_ren    (w_ren[b]),
            .i_raddr  (bus.raddr[b*HLEN +: HLEN]),
            .o_dout   (bus.dout[b*DLEN +: DLEN]),
            .o_dvalid (bus.dvalid[b])
         );
      end
   endgenerate

endmodule

// File: tb/tb_ntt_banked_ram.sv
// Directed self-checking bench for ntt_banked_ram:
// reset, read/write, collisions, clear sequencer and mid-clear reset.
module tb_ntt_banked_ram;

   localparam int DLEN  = 23;
   localparam int HLEN  = 8;
   localparam int NBANK = 4;
   localparam int OREG  = 0;
   localparam int DEPTH = 1 << HLEN;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   ntt_banked_ram_if #(
      .DLEN  (DLEN),
      .HLEN  (HLEN),
      .NBANK (NBANK)
   ) bus ();

   ntt_banked_ram #(
      .DLEN  (DLEN),
      .HLEN  (HLEN),
      .NBANK (NBANK),
      .OREG  (OREG)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int ntests = 0;
   int nfail  = 0;

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DLEN-1:0] fv(int b, int a);
      return DLEN'(32'h400000 | (b << 12) | a);
   endfunction

   task automatic wr1(int b, int a, logic [DLEN-1:0] d);
      bus.wen = '0;
      bus.wen[b] = 1'b1;
      bus.waddr[b*HLEN +: HLEN] = HLEN'(a);
      bus.din[b*DLEN +: DLEN] = d;
      tick();
      bus.wen = '0;
   endtask

   task automatic rd1(int b, int a,
                      output logic [DLEN-1:0] d,
                      output logic [NBANK-1:0] v);
      bus.ren = '0;
      bus.ren[b] = 1'b1;
      bus.raddr[b*HLEN +: HLEN] = HLEN'(a);
      tick();
      bus.ren = '0;
      repeat (OREG) tick();
      d = bus.dout[b*DLEN +: DLEN];
      v = bus.dvalid;
   endtask

   task automatic fill_all();
      for (int a = 0; a < DEPTH; a++) begin
         for (int b = 0; b < NBANK; b++) begin
            bus.waddr[b*HLEN +: HLEN] = HLEN'(a);
            bus.din[b*DLEN +: DLEN] = fv(b, a);
         end
         bus.wen = '1;
         tick();
      end
      bus.wen = '0;
   endtask

   task automatic read_chk(string tag, int lo, int hi, bit zero);
      int errs;
      logic [DLEN-1:0] e;
      errs = 0;
      for (int a = lo; a <= hi; a++) begin
         for (int b = 0; b < NBANK; b++)
            bus.raddr[b*HLEN +: HLEN] = HLEN'(a);
         bus.ren = '1;
         tick();
         bus.ren = '0;
         repeat (OREG) tick();
         if (bus.dvalid !== '1) errs++;
         for (int b = 0; b < NBANK; b++) begin
            e = zero ? '0 : fv(b, a);
            if (bus.dout[b*DLEN +: DLEN] !== e) errs++;
         end
      end
      chk(tag, 128'(errs), 128'd0);
   endtask

   task automatic run_clear(input int pulse_at,
                            output int cycles, output int bad);
      cycles = 0;
      bad = 0;
      while (bus.clr_bsy === 1'b1 && cycles < 1000) begin
         cycles++;
         if (bus.dvalid !== '0) bad++;
         bus.clr_req = (cycles == pulse_at);
         tick();
      end
      bus.clr_req = 1'b0;
      bus.wen = '0;
      bus.ren = '0;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DLEN-1:0] d;
      logic [NBANK-1:0] v;
      int cyc;
      int bad;

      bus.clr_req = 1'b0;
      bus.wen = '0;
      bus.waddr = '0;
      bus.din = '0;
      bus.ren = '0;
      bus.raddr = '0;

      // Reset state
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("reset_dvalid", 128'(bus.dvalid), 128'd0);
      chk("reset_dout", 128'(bus.dout), 128'd0);
      chk("reset_bsy", 128'(bus.clr_bsy), 128'd0);

      // 1: read all banks at addr 0, valid latency
      bus.ren = '1;
      bus.raddr = '0;
      tick();
      bus.ren = '0;
      repeat (OREG) tick();
      chk("t1_dvalid_rise", 128'(bus.dvalid), 128'hF);
      tick();
      chk("t1_dvalid_fall", 128'(bus.dvalid), 128'h0);

      // 2: single-bank write/read, neighbours untouched
      for (int b = 0; b < NBANK; b++) begin
         bus.waddr[b*HLEN +: HLEN] = 8'd5;
         bus.din[b*DLEN +: DLEN] = fv(b, 5);
      end
      bus.wen = '1;
      tick();
      bus.wen = '0;
      wr1(1, 5, 23'h1234);
      rd1(1, 5, d, v);
      chk("t2_dout1", 128'(d), 128'h1234);
      chk("t2_dvalid", 128'(v), 128'b0010);
      rd1(0, 5, d, v);
      chk("t2_bank0", 128'(d), 128'(fv(0, 5)));
      rd1(3, 5, d, v);
      chk("t2_bank3", 128'(d), 128'(fv(3, 5)));
      chk("t2_hold1", 128'(bus.dout[1*DLEN +: DLEN]), 128'h1234);

      // 3: same-cycle read+write collision
      wr1(0, 7, 23'hA);
      bus.wen = 4'b0001;
      bus.ren = 4'b0001;
      bus.waddr[0 +: HLEN] = 8'd7;
      bus.raddr[0 +: HLEN] = 8'd7;
      bus.din[0 +: DLEN] = 23'hB;
      tick();
      bus.wen = '0;
      bus.ren = '0;
      repeat (OREG) tick();
`ifdef NTT_BANKED_RAM_FWD_EN
      chk("t3_collide", 128'(bus.dout[0 +: DLEN]), 128'hB);
`else
      chk("t3_collide", 128'(bus.dout[0 +: DLEN]), 128'hA);
`endif
      rd1(0, 7, d, v);
      chk("t3_after", 128'(d), 128'hB);

      // 4: fill, clear, user traffic ignored while busy
      fill_all();
      rd1(2, 200, d, v);
      chk("t4_filled", 128'(d), 128'(fv(2, 200)));
      bus.clr_req = 1'b1;
      tick();
      bus.clr_req = 1'b0;
      chk("t4_bsy_rise", 128'(bus.clr_bsy), 128'd1);
      bus.wen = '1;
      bus.din = '1;
      bus.ren = '1;
      bus.waddr = '0;
      bus.raddr = '0;
      run_clear(-1, cyc, bad);
      chk("t4_bsy_cycles", 128'(cyc), 128'd256);
      chk("t4_ren_ignored", 128'(bad), 128'd0);
      read_chk("t4_all_zero", 0, DEPTH - 1, 1'b1);

      // 5: clr_req beats same-cycle write; second request ignored
      wr1(2, 3, 23'h55);
      bus.clr_req = 1'b1;
      bus.wen = 4'b0100;
      bus.waddr[2*HLEN +: HLEN] = 8'd3;
      bus.din[2*DLEN +: DLEN] = 23'h77;
      tick();
      bus.clr_req = 1'b0;
      bus.wen = '0;
      run_clear(10, cyc, bad);
      chk("t5_bsy_cycles", 128'(cyc), 128'd256);
      rd1(2, 3, d, v);
      chk("t5_addr3_zero", 128'(d), 128'd0);

      // 6: reset mid-clear at cnt=100
      fill_all();
      bus.clr_req = 1'b1;
      tick();
      bus.clr_req = 1'b0;
      repeat (100) tick();
      rst_n = 1'b0;
      #1;
      chk("t6_bsy_async", 128'(bus.clr_bsy), 128'd0);
      chk("t6_dvalid_rst", 128'(bus.dvalid), 128'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("t6_idle", 128'(bus.clr_bsy), 128'd0);
      read_chk("t6_cleared", 0, 99, 1'b1);
      read_chk("t6_kept", 101, DEPTH - 1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
